// File: rtl/elastic_pipe_pkg.sv
// rtl/elastic_pipe_pkg.sv - shared stage state type and sizing helper for the elastic pipeline
package elastic_pkg;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} stage_state_t;

  // Width of a counter that must hold 0..2*stages (main + skid per stage)
  function automatic int count_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// rtl/elastic_pipe_if.sv - valid/ready/data beat channel for the elastic pipeline
interface elastic_pipe_if #(
  parameter int n = 4
);
  logic         valid;
  logic         ready;
  logic [n-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_pipe_stage.sv
// rtl/elastic_pipe_stage.sv - one elastic stage: main register plus skid entry, registered in_ready
module elastic_stage
  import elastic_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [n-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [n-1:0] out_data_o
);

  stage_state_t state_q, state_d;
  logic [n-1:0] main_q, main_d;
  logic [n-1:0] skid_q, skid_d;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid_i & (state_q != FULL);
  assign out_xfer = out_ready_i & (state_q != EMPTY);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_xfer) state_d = BUSY;
      BUSY: begin
        if (in_xfer && !out_xfer)      state_d = FULL;
        else if (!in_xfer && out_xfer) state_d = EMPTY;
      end
      FULL:    if (out_xfer) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
    if (clr) state_d = EMPTY;
  end

  // Ready comes from the state register only, so out_ready never reaches in_ready
  always_comb begin
    in_ready_o  = (state_q != FULL);
    out_valid_o = (state_q != EMPTY);
    out_data_o  = main_q;
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!clr) begin
      case (state_q)
        EMPTY: if (in_xfer) main_d = in_data_i;
        BUSY: begin
          if (in_xfer && out_xfer) main_d = in_data_i;
          else if (in_xfer)        skid_d = in_data_i;
        end
        FULL:    if (out_xfer) main_d = skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - chain of STAGES elastic stages with a held-beat counter
module elastic_pipe
  import elastic_pkg::*;
#(
  parameter int n      = 4,
  parameter int STAGES = 2
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            clr,
  elastic_pipe_if.slave                   in_if,
  elastic_pipe_if.master                  out_if,
  output logic [$clog2(2*STAGES+1)-1:0]   count
);

  localparam int CW = count_width(STAGES);

  logic [STAGES:0] valid_w;
  logic [STAGES:0] ready_w;
  logic [n-1:0]    data_w [0:STAGES];
  logic [CW-1:0]   count_q, count_d;
  logic            in_xfer;
  logic            out_xfer;

  assign valid_w[0]    = in_if.valid;
  assign data_w[0]     = in_if.data;
  assign in_if.ready   = ready_w[0];
  assign out_if.valid  = valid_w[STAGES];
  assign out_if.data   = data_w[STAGES];
  assign ready_w[STAGES] = out_if.ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    elastic_stage #(.n(n)) u_stage (
      .clk         (clk),
      .nrst        (nrst),
      .clr         (clr),
      .in_valid_i  (valid_w[k]),
      .in_ready_o  (ready_w[k]),
      .in_data_i   (data_w[k]),
      .out_valid_o (valid_w[k+1]),
      .out_ready_i (ready_w[k+1]),
      .out_data_o  (data_w[k+1])
    );
  end

  assign in_xfer  = in_if.valid & ready_w[0];
  assign out_xfer = valid_w[STAGES] & out_if.ready;

  always_comb begin
    count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    if (clr) count_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// tb/tb_elastic_pipe.sv - scoreboard bench for elastic_pipe (n=8/STAGES=2 and n=1/STAGES=1)
module tb_elastic_pipe;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic       clr  = 1'b0;
  logic [2:0] a_cnt;
  logic [1:0] b_cnt;

  elastic_pipe_if #(.n(8)) a_in ();
  elastic_pipe_if #(.n(8)) a_out ();
  elastic_pipe_if #(.n(1)) b_in ();
  elastic_pipe_if #(.n(1)) b_out ();

  elastic_pipe #(.n(8), .STAGES(2)) dut_a (
    .clk(clk), .nrst(nrst), .clr(clr), .in_if(a_in), .out_if(a_out), .count(a_cnt)
  );
  elastic_pipe #(.n(1), .STAGES(1)) dut_b (
    .clk(clk), .nrst(nrst), .clr(clr), .in_if(b_in), .out_if(b_out), .count(b_cnt)
  );

  int         n_cmp  = 0;
  int         n_bad  = 0;
  int         a_pops = 0;
  logic [7:0] qa[$];
  logic       qb[$];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: push accepted beats, pop and compare delivered beats
  always @(negedge clk) begin
    if (!nrst || clr) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out.valid && a_out.ready) begin
        a_pops++;
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_beat: got 0x%0h expected no beat", a_out.data);
        end else chk("a_out_data", 32'(a_out.data), 32'(qa.pop_front()));
      end
      if (a_in.valid && a_in.ready) qa.push_back(a_in.data);
      if (b_out.valid && b_out.ready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_beat: got 0x%0h expected no beat", b_out.data);
        end else chk("b_out_data", 32'(b_out.data), 32'(qb.pop_front()));
      end
      if (b_in.valid && b_in.ready) qb.push_back(b_in.data);
    end
  end

  task automatic send_a(input logic [7:0] d);
    int g = 0;
    a_in.valid = 1'b1;
    a_in.data  = d;
    while (!a_in.ready && g < 50) begin step(); g++; end
    chk("a_send_bound", 32'(g < 50), 1);
    step();
  endtask

  task automatic send_b(input logic d);
    int g = 0;
    b_in.valid = 1'b1;
    b_in.data  = d;
    while (!b_in.ready && g < 50) begin step(); g++; end
    chk("b_send_bound", 32'(g < 50), 1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    int  rec;
    logic acc;
    a_in.valid = 0; a_in.data = '0; a_out.ready = 0;
    b_in.valid = 0; b_in.data = '0; b_out.ready = 0;

    #1;
    chk("rst_a_in_ready",  32'(a_in.ready), 1);
    chk("rst_a_out_valid", 32'(a_out.valid), 0);
    chk("rst_a_count",     32'(a_cnt), 0);
    chk("rst_a_out_data",  32'(a_out.data), 0);
    chk("rst_b_in_ready",  32'(b_in.ready), 1);
    chk("rst_b_out_valid", 32'(b_out.valid), 0);
    step();
    nrst = 1'b1;
    step();

    // Streaming 0x01..0x10 with out_ready held high
    a_out.ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      a_in.valid = 1'b1;
      a_in.data  = 8'(i);
      chk("stream_in_ready", 32'(a_in.ready), 1);
      step();
      if (i == 1) chk("stream_latency_gap", 32'(a_out.valid), 0);
      else begin
        chk("stream_out_valid", 32'(a_out.valid), 1);
        chk("stream_count", 32'(a_cnt), 2);
      end
      if (i == 2) chk("stream_first_data", 32'(a_out.data), 32'h01);
    end
    a_in.valid = 1'b0;
    step(); step();
    chk("stream_drained_count", 32'(a_cnt), 0);

    // Backpressure: offer 0xA0..0xA5 with out_ready low
    a_out.ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      a_in.valid = 1'b1;
      a_in.data  = 8'(8'hA0 + idx);
      acc = a_in.ready;
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 4);
    chk("bp_in_ready", 32'(a_in.ready), 0);
    chk("bp_count", 32'(a_cnt), 4);
    a_out.ready = 1'b1;
    rec = 0;
    while (!a_in.ready && rec < 10) begin step(); rec++; end
    chk("bp_recovery_le_stages", 32'(rec <= 2), 1);
    while (idx < 6) begin send_a(8'(8'hA0 + idx)); idx++; end
    a_in.valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("bp_drained_count", 32'(a_cnt), 0);
    chk("bp_sb_empty", 32'(qa.size()), 0);

    // Alternating out_ready with in_valid held, data 0..31
    idx = 0;
    a_pops = 0;
    for (int c = 0; c < 200 && idx < 32; c++) begin
      a_in.valid  = 1'b1;
      a_in.data   = 8'(idx);
      a_out.ready = (c % 2 == 0);
      acc = a_in.ready;
      step();
      if (acc) idx++;
      chk("alt_count_le4", 32'(a_cnt <= 4), 1);
    end
    chk("alt_all_sent", 32'(idx), 32);
    a_in.valid  = 1'b0;
    a_out.ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    chk("alt_pops", 32'(a_pops), 32);
    chk("alt_sb_empty", 32'(qa.size()), 0);

    // Flush with three beats held and both handshakes active
    a_out.ready = 1'b0;
    send_a(8'h11); send_a(8'h22); send_a(8'h33);
    chk("clr_pre_count", 32'(a_cnt), 3);
    a_in.data   = 8'hEE;
    a_out.ready = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    a_in.valid = 1'b0;
    chk("clr_count", 32'(a_cnt), 0);
    chk("clr_out_valid", 32'(a_out.valid), 0);
    chk("clr_in_ready", 32'(a_in.ready), 1);
    a_in.valid = 1'b1;
    a_in.data  = 8'h5A;
    step();
    a_in.valid = 1'b0;
    chk("post_clr_gap", 32'(a_out.valid), 0);
    step();
    chk("post_clr_valid", 32'(a_out.valid), 1);
    chk("post_clr_data", 32'(a_out.data), 32'h5A);
    step();
    chk("post_clr_count", 32'(a_cnt), 0);

    // Asynchronous reset mid-stream
    a_out.ready = 1'b0;
    send_a(8'h77); send_a(8'h78);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(a_out.valid), 0);
    chk("arst_in_ready", 32'(a_in.ready), 1);
    chk("arst_count", 32'(a_cnt), 0);
    chk("arst_out_data", 32'(a_out.data), 0);
    a_in.valid = 1'b0;
    step();
    nrst = 1'b1;
    a_out.ready = 1'b1;
    step(); step();
    chk("arst_no_ghost", 32'(a_out.valid), 0);

    // Single stage, 1-bit: latency 1, capacity 2, order 1,0,1
    b_out.ready = 1'b0;
    b_in.valid  = 1'b1;
    b_in.data   = 1'b1;
    step();
    chk("b_latency_valid", 32'(b_out.valid), 1);
    chk("b_latency_data", 32'(b_out.data), 1);
    b_in.data = 1'b0;
    step();
    chk("b_cap_count", 32'(b_cnt), 2);
    chk("b_cap_in_ready", 32'(b_in.ready), 0);
    b_in.data = 1'b1;
    step();
    chk("b_cap_hold", 32'(b_cnt), 2);
    b_out.ready = 1'b1;
    send_b(1'b1);
    b_in.valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("b_drained_count", 32'(b_cnt), 0);
    chk("b_sb_empty", 32'(qb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised successor to the codebase's single-stage reset flop. It is a chain of `STAGES` elastic register stages, each `n` bits wide, with a valid/ready handshake on both sides. Every stage has a skid entry, so `in_ready` is purely registered and has no combinational path from `out_ready`. The block retimes and decouples datapaths around the async FIFO (for example, write-side producers and read-side consumers) without losing throughput under backpressure.

## Interface
- `n`, default 4: data width in bits, ≥1.
- `STAGES`, default 2: number of elastic stages, ≥1.
- `clk` input 1: single clock; all state updates on posedge.
- `nrst` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous flush of all stages.
- `in_valid` input 1: upstream beat present.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_data` input `n`: upstream data.
- `out_valid` output 1: beat present at the output.
- `out_ready` input 1: downstream accepts the beat.
- `out_data` output `n`: output data.
- `count` output `$clog2(2*STAGES+1)`: beats currently held, range 0..2·STAGES.

## Operation
- Clock and reset: one clock, `clk`. Reset `nrst` is asynchronous and active-low.
- Transfers: a transfer occurs on a posedge where valid and ready are both 1, on either side.
- Stage FSM, per stage with states EMPTY / BUSY / FULL:
  - EMPTY: the main register is invalid.
  - BUSY: the main register is valid, the skid register is empty.
  - FULL: both the main and skid registers are valid.
- Stage outputs:
  - stage `in_ready` = (state ≠ FULL), decoded from the state register only.
  - stage `out_valid` = (state ≠ EMPTY).
  - stage `out_data` = main register.
- Stage transitions (i = input transfer, o = output transfer):
  - EMPTY, i → BUSY; main ← in.
  - BUSY, i & o → BUSY; main ← in.
  - BUSY, i & !o → FULL; skid ← in.
  - BUSY, !i & o → EMPTY.
  - FULL, o → BUSY; main ← skid. No input is accepted in FULL.
  - All other cases hold state and data.
- Chaining: stage k output feeds stage k+1 input. Block `in_*` connects to stage 0; block `out_*` connects to stage STAGES-1.
- Ordering: beats leave in the order accepted. No beat is dropped or duplicated.
- `count`: registered. It increments on an input transfer and decrements on an output transfer. Both together leave it unchanged.
- `clr`: all stages go to EMPTY and `count` goes to 0 at the next edge. `clr` has priority over both handshakes; any transfer in that cycle is discarded. Data registers are not cleared.
- Reset values:
  - every stage is EMPTY, so `out_valid` = 0 and `in_ready` = 1 (also while `nrst` is asserted).
  - `count` = 0.
  - `out_data` = 0, with all main and skid registers = 0.
- Reset mid-operation: all held beats are lost immediately (asynchronously). No partial beat may appear at the output afterwards.

## Timing
- Latency, empty pipe: a beat accepted in cycle c has `out_valid` = 1 with that beat from cycle c+STAGES.
- Throughput: one beat per cycle sustained while `out_ready` = 1.
- Backpressure: with `out_ready` held at 0, the block accepts exactly 2·STAGES beats. `in_ready` falls in the cycle after the last accept.
- Recovery: when `out_ready` rises, `in_ready` returns to 1 within STAGES cycles.
- Combinational paths: no path from `out_ready` to `in_ready`, nor from `in_valid` to `out_valid`.
- `out_valid` is stable: it stays 1 with `out_data` unchanged until the output transfer occurs (except on `clr` or `nrst`).

## Structure
- Shared package `elastic_pkg`: `typedef enum logic [1:0] {EMPTY, BUSY, FULL} stage_state_t`.
- Sub-module `elastic_stage #(n)`: one FSM plus main and skid registers, with ports `clk`, `nrst`, `clr`, and in/out valid/ready/data.
- Top level: a generate loop of `STAGES` instances of `elastic_stage`, plus the `count` register.

## Test plan
- Reset: assert `nrst`=0 mid-stream → immediately `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=0.
- Streaming (n=8, STAGES=2, `out_ready`=1): send 0x01..0x10 back-to-back → output is 0x01..0x10 in order on consecutive cycles; first beat appears 2 cycles after its accept; `count` steady at 2.
- Backpressure (STAGES=2, `out_ready`=0): offer 0xA0..0xA5 → 0xA0..0xA3 accepted, `in_ready`=0, `count`=4. Then `out_ready`=1 → 0xA0..0xA5 emerge in order with none lost.
- Alternating `out_ready` 1010…, with `in_valid` constant and data 0..31 → all 32 beats emerge exactly once, in order; `count` never exceeds 4.
- `clr` with 3 beats held and simultaneous `in_valid`=`out_ready`=1 → next cycle `count`=0 and `out_valid`=0, and the offered beat is discarded. The following beat 0x5A emerges after 2 cycles.
- STAGES=1, n=1 → capacity 2, latency 1, ordering preserved.
